// File: rtl/mac_sched_pkg.sv
// Shared types for the MAC job scheduler: FSM state encoding and drain-counter width.
package mac_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    BUSY,
    DRAIN,
    RESP
  } state_t;

  // Wide enough for any practical datapath latency (up to 255 cycles).
  localparam int unsigned LAT_CNT_W = 8;

endpackage

// File: rtl/mac_sched_arb.sv
// Combinational N-way arbiter: first set request at or after i_ptr wins.
// Used as fixed priority by tying i_ptr to zero.
module mac_sched_arb #(
  parameter int p_nreq = 4
) (
  input  logic [p_nreq-1:0]         i_req,
  input  logic [$clog2(p_nreq)-1:0] i_ptr,
  output logic [p_nreq-1:0]         o_gnt,
  output logic [$clog2(p_nreq)-1:0] o_idx,
  output logic                      o_any
);

  localparam int p_iw = $clog2(p_nreq);

  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < p_nreq; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= p_nreq) w_j = w_j - p_nreq;
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = p_iw'(w_j);
      end
    end
  end

endmodule

// File: rtl/mac_sched.sv
// Job scheduler for the shared MAC datapath: grants one requester per job, issues beats,
// waits out the pipeline and returns the sum. Define MAC_SCHED_RR_EN for round-robin.
module mac_sched
  import mac_sched_pkg::*;
#(
  parameter int p_nbits = 32,
  parameter int p_nreq  = 4,
  parameter int p_lat   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [p_nreq-1:0]           req_val,
  output logic [p_nreq-1:0]           req_rdy,
  input  logic [p_nreq*p_nbits-1:0]   req_a,
  input  logic [p_nreq*p_nbits-1:0]   req_b,
  input  logic [p_nreq-1:0]           req_last,
  output logic                        dp_val,
  output logic                        dp_clr,
  output logic [p_nbits-1:0]          dp_a,
  output logic [p_nbits-1:0]          dp_b,
  input  logic [p_nbits-1:0]          dp_out,
  output logic                        resp_val,
  input  logic                        resp_rdy,
  output logic [p_nbits-1:0]          resp_data,
  output logic [$clog2(p_nreq)-1:0]   resp_id
);

  localparam int p_iw = $clog2(p_nreq);

  state_t                 r_state, w_state_next;
  logic [p_nreq-1:0]      r_gnt_oh;
  logic [p_iw-1:0]        r_gnt_idx;
  logic                   r_first;
  logic [LAT_CNT_W-1:0]   r_cnt;
  logic                   r_dp_val, r_dp_clr;
  logic [p_nbits-1:0]     r_dp_a, r_dp_b;
  logic [p_nbits-1:0]     r_resp_data;
  logic [p_iw-1:0]        r_resp_id;

  logic [p_nreq-1:0]      w_arb_gnt;
  logic [p_iw-1:0]        w_arb_idx;
  logic                   w_arb_any;
  logic [p_iw-1:0]        w_ptr;
  logic                   w_grant;
  logic                   w_accept;
  logic                   w_last;
  logic                   w_drain_done;
  logic [p_nbits-1:0]     w_a, w_b;

  assign w_grant      = (r_state == IDLE) && w_arb_any;
  assign w_accept     = (r_state == BUSY) && |(req_val & r_gnt_oh);
  assign w_last       = |(req_last & r_gnt_oh);
  assign w_drain_done = (r_state == DRAIN) && (r_cnt == LAT_CNT_W'(p_lat));
  assign w_a          = req_a[r_gnt_idx*p_nbits +: p_nbits];
  assign w_b          = req_b[r_gnt_idx*p_nbits +: p_nbits];

`ifdef MAC_SCHED_RR_EN
  logic [p_iw-1:0] r_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_arb_idx == p_iw'(p_nreq - 1)) ? '0 : w_arb_idx + 1'b1;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  mac_sched_arb #(.p_nreq(p_nreq)) u_arb (
    .i_req (req_val),
    .i_ptr (w_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_rdy      = '0;
    resp_val     = 1'b0;
    case (r_state)
      IDLE:  if (w_arb_any) w_state_next = GRANT;
      GRANT: w_state_next = BUSY;
      BUSY: begin
        req_rdy = r_gnt_oh;
        if (w_accept && w_last) w_state_next = DRAIN;
      end
      DRAIN: if (w_drain_done) w_state_next = RESP;
      RESP: begin
        resp_val = 1'b1;
        if (resp_rdy) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt_oh  <= '0;
      r_gnt_idx <= '0;
      r_first   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_gnt_oh  <= w_arb_gnt;
        r_gnt_idx <= w_arb_idx;
      end
      if (r_state == GRANT) r_first <= 1'b1;
      else if (w_accept)    r_first <= 1'b0;
    end
  end

  // Operands hold their last value between beats; only dp_val qualifies them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dp_val <= 1'b0;
      r_dp_clr <= 1'b0;
      r_dp_a   <= '0;
      r_dp_b   <= '0;
    end else begin
      r_dp_val <= w_accept;
      r_dp_clr <= w_accept && r_first;
      if (w_accept) begin
        r_dp_a <= w_a;
        r_dp_b <= w_b;
      end
    end
  end

  // Counter is zero on DRAIN entry, which coincides with the final dp_val cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state != DRAIN) begin
      r_cnt <= '0;
    end else if (!w_drain_done) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_data <= '0;
      r_resp_id   <= '0;
    end else if (w_drain_done) begin
      r_resp_data <= dp_out;
      r_resp_id   <= r_gnt_idx;
    end
  end

  assign dp_val    = r_dp_val;
  assign dp_clr    = r_dp_clr;
  assign dp_a      = r_dp_a;
  assign dp_b      = r_dp_b;
  assign resp_data = r_resp_data;
  assign resp_id   = r_resp_id;

endmodule

// File: tb/tb_mac_sched.sv
// Directed bench for mac_sched with a behavioural two-stage MAC datapath.
// Honours MAC_SCHED_RR_EN for the contention expectations.
module tb_mac_sched;

  localparam int NB = 10;
  localparam int NR = 4;
  localparam int LT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_val;
  logic [NR-1:0]     req_rdy;
  logic [NR*NB-1:0]  req_a;
  logic [NR*NB-1:0]  req_b;
  logic [NR-1:0]     req_last;
  logic              dp_val;
  logic              dp_clr;
  logic [NB-1:0]     dp_a;
  logic [NB-1:0]     dp_b;
  logic [NB-1:0]     dp_out;
  logic              resp_val;
  logic              resp_rdy;
  logic [NB-1:0]     resp_data;
  logic [1:0]        resp_id;

  int n_checks = 0;
  int n_errors = 0;
  int job_a[8];
  int job_b[8];

  always #5 clk = ~clk;

  mac_sched #(.p_nbits(NB), .p_nreq(NR), .p_lat(LT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_last  (req_last),
    .dp_val    (dp_val),
    .dp_clr    (dp_clr),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_out    (dp_out),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_data (resp_data),
    .resp_id   (resp_id)
  );

  // Datapath model: product register, then accumulator (dp_val to dp_out = 2 cycles).
  logic [NB-1:0] m_prod, m_acc;
  logic          m_val, m_clr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_prod <= '0; m_acc <= '0; m_val <= 1'b0; m_clr <= 1'b0;
    end else begin
      m_prod <= NB'(dp_a * dp_b);
      m_val  <= dp_val;
      m_clr  <= dp_clr;
      if (m_val) m_acc <= (m_clr ? '0 : m_acc) + m_prod;
    end
  end
  assign dp_out = m_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_beat(input int id, input int beat, input int n);
    req_val[id]           = 1'b1;
    req_a[id*NB +: NB]    = job_a[beat][NB-1:0];
    req_b[id*NB +: NB]    = job_b[beat][NB-1:0];
    req_last[id]          = (beat == n - 1);
  endtask

  // Runs one job from requester id using job_a/job_b, then handshakes the response.
  task automatic run_job(input string tag, input int id, input int n, input int gap_at,
                         input int gap_len, input int exp_data, input int chk_lat,
                         input int hold);
    int beat = 0, gap_left = 0, cyc = 0, mism = 0, nval = 0, nclr = 0, lat;
    logic acc, first_clr = 1'b0;
    logic [NB-1:0] d0;
    logic [1:0] i0;
    drive_beat(id, 0, n);
    while (beat < n && cyc < 200) begin
      acc = req_val[id] & req_rdy[id];
      @(posedge clk); #1;
      cyc++;
      if (dp_val !== acc) mism++;
      if (!dp_val && dp_clr) mism++;
      if (dp_val) begin
        nval++;
        if (dp_clr) nclr++;
        if (nval == 1) first_clr = dp_clr;
      end
      if (acc) begin
        beat++;
        if (beat == n) begin
          req_val[id] = 1'b0; req_last[id] = 1'b0;
        end else if (beat == gap_at && gap_len > 0) begin
          req_val[id] = 1'b0; gap_left = gap_len;
        end else begin
          drive_beat(id, beat, n);
        end
      end else if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) drive_beat(id, beat, n);
      end
    end
    chk({tag, "_beats"}, beat, n);
    lat = 1;
    while (!resp_val && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (dp_val) mism++;
    end
    chk({tag, "_resp_val"}, resp_val, 1);
    if (chk_lat != 0) chk({tag, "_latency"}, lat, 2 + LT);
    chk({tag, "_issue"}, mism, 0);
    chk({tag, "_nval"}, nval, n);
    chk({tag, "_nclr"}, nclr, 1);
    chk({tag, "_first_clr"}, first_clr, 1);
    chk({tag, "_data"}, resp_data, exp_data);
    chk({tag, "_id"}, resp_id, id);
    if (hold > 0) begin
      d0 = resp_data; i0 = resp_id; mism = 0;
      req_val = '1; req_last = '1;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        if (resp_val !== 1'b1 || resp_data !== d0 || resp_id !== i0) mism++;
        if (req_rdy !== '0 || dp_val !== 1'b0) mism++;
      end
      req_val = '0; req_last = '0;
      chk({tag, "_hold"}, mism, 0);
    end
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    chk({tag, "_hsk"}, resp_val, 0);
    $display("job %s id %0d beats %0d data %0d", tag, id, n, d0 === 'x ? resp_data : resp_data);
  endtask

  initial begin
    int got;
    int ids[4];
    int dat[4];
`ifdef MAC_SCHED_RR_EN
    int exp_ids[4] = '{0, 1, 0, 1};
    int nexp = 4;
`else
    int exp_ids[4] = '{0, 0, 0, 0};
    int nexp = 3;
`endif
    reset = 1'b1; req_val = '0; req_a = '0; req_b = '0; req_last = '0; resp_rdy = 1'b0;
    #12;
    chk("reset_outputs", {req_rdy, dp_val, dp_clr, dp_a, dp_b, resp_val, resp_data, resp_id}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_rdy", req_rdy, 0);

    job_a = '{1, 3, 10, 2, 5, 0, 0, 0};
    job_b = '{2, 10, 1, 12, 13, 0, 0, 0};
    run_job("single", 0, 5, 0, 0, 131, 1, 0);

    job_a = '{31, 1, 0, 0, 0, 0, 0, 0};
    job_b = '{33, 1, 0, 0, 0, 0, 0, 0};
    run_job("wrap_bp", 2, 2, 0, 0, 0, 1, 5);

    job_a = '{3, 4, 0, 0, 0, 0, 0, 0};
    job_b = '{3, 4, 0, 0, 0, 0, 0, 0};
    run_job("gaps", 3, 2, 1, 3, 25, 0, 0);

    // Contention: req0 and req1 always valid, single-beat jobs.
    req_a[0*NB +: NB] = 10'd3; req_b[0*NB +: NB] = 10'd4;
    req_a[1*NB +: NB] = 10'd5; req_b[1*NB +: NB] = 10'd6;
    req_val = 4'b0011; req_last = 4'b0011; resp_rdy = 1'b1;
    got = 0;
    for (int c = 0; c < 200 && got < nexp; c++) begin
      @(posedge clk); #1;
      if (resp_val) begin
        ids[got] = int'(resp_id); dat[got] = int'(resp_data);
        $display("job cont id %0d data %0d", resp_id, resp_data);
        got++;
        if (got == nexp) begin
          req_val = '0; req_last = '0;
        end
      end
    end
    req_val = '0; req_last = '0;
    chk("cont_count", got, nexp);
    for (int k = 0; k < got; k++) begin
      chk("cont_id", ids[k], exp_ids[k]);
      chk("cont_data", dat[k], (exp_ids[k] == 0) ? 12 : 30);
    end
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a job from req1.
    req_a[1*NB +: NB] = 10'd7; req_b[1*NB +: NB] = 10'd7;
    req_val[1] = 1'b1; req_last[1] = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && !req_rdy[1]; c++) begin
      @(posedge clk); #1;
    end
    chk("mid_rdy", req_rdy, 4'b0010);
    @(posedge clk); #1;
    chk("mid_dp_val", dp_val, 1);
    #3 reset = 1'b1;
    #1;
    chk("mid_reset_outputs", {req_rdy, dp_val, dp_clr, dp_a, dp_b, resp_val, resp_data, resp_id}, 0);
    req_val = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    job_a = '{2, 0, 0, 0, 0, 0, 0, 0};
    job_b = '{3, 0, 0, 0, 0, 0, 0, 0};
    run_job("after_reset", 1, 1, 0, 0, 6, 1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
